// File: rtl/hwpe_axi_addressgen_source_nd.sv
// Multi-stream source address generator: walks a word/line/feature loop and
// presents NPX lane addresses per stream on each valid/ready beat.
module hwpe_axi_addressgen_source_nd #(
    parameter int ADDR_WIDTH = 32,
    parameter int N_STREAMS  = 4,
    parameter int NPX        = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_i,
    input  logic                                  clear_i,
    input  logic [N_STREAMS*ADDR_WIDTH-1:0]       base_addr_i,
    input  logic [15:0]                           word_stride_i,
    input  logic [CNT_BITS-1:0]                   line_length_i,
    input  logic [15:0]                           line_stride_i,
    input  logic [CNT_BITS-1:0]                   feat_length_i,
    input  logic [15:0]                           feat_stride_i,
    input  logic [CNT_BITS-1:0]                   n_feat_i,
    output logic                                  addr_valid_o,
    input  logic                                  addr_ready_i,
    output logic [N_STREAMS*NPX*ADDR_WIDTH-1:0]   gen_addr_o,
    output logic [NPX-1:0]                        lane_mask_o,
    output logic                                  word_update_o,
    output logic                                  line_update_o,
    output logic                                  feat_update_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    localparam int AW = ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state_q, state_d;
    logic [CNT_BITS-1:0]          w_q, w_d, l_q, l_d, f_q, f_d;
    logic [AW-1:0]                word_acc_q, word_acc_d;
    logic [AW-1:0]                line_acc_q, line_acc_d;
    logic [AW-1:0]                feat_acc_q, feat_acc_d;

    // Latched configuration; strides are kept already sign-extended.
    logic [N_STREAMS*AW-1:0]      base_q;
    logic [AW-1:0]                ws_q, ls_q, fs_q;
    logic [CNT_BITS-1:0]          len_q, flen_q, nfeat_q;

    logic                         run;
    logic                         accept;
    logic                         cfg_load;
    logic                         word_upd, line_upd, feat_upd;
    logic [AW-1:0]                word_step;

    function automatic logic [AW-1:0] sext16(input logic [15:0] v);
        return {{(AW-16){v[15]}}, v};
    endfunction

    assign run       = (state_q == RUN);
    assign accept    = run && addr_ready_i;
    assign cfg_load  = (state_q == IDLE) && start_i && !clear_i;
    // Guard bit keeps w+NPX from wrapping when L is close to 2^CNT_BITS.
    assign word_upd  = ({1'b0, w_q} + (CNT_BITS+1)'(NPX)) >= {1'b0, len_q};
    assign line_upd  = word_upd && (l_q == flen_q - 1'b1);
    assign feat_upd  = line_upd && (f_q == nfeat_q - 1'b1);
    // Constant-coefficient product: advance of the word accumulator per beat.
    assign word_step = AW'(NPX) * ws_q;

    // Configuration capture on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q  <= '0;
            ws_q    <= '0;
            ls_q    <= '0;
            fs_q    <= '0;
            len_q   <= '0;
            flen_q  <= '0;
            nfeat_q <= '0;
        end else if (cfg_load) begin
            base_q  <= base_addr_i;
            ws_q    <= sext16(word_stride_i);
            ls_q    <= sext16(line_stride_i);
            fs_q    <= sext16(feat_stride_i);
            len_q   <= line_length_i;
            flen_q  <= feat_length_i;
            nfeat_q <= n_feat_i;
        end
    end

    // State, loop counters and address accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            w_q        <= '0;
            l_q        <= '0;
            f_q        <= '0;
            word_acc_q <= '0;
            line_acc_q <= '0;
            feat_acc_q <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            l_q        <= l_d;
            f_q        <= f_d;
            word_acc_q <= word_acc_d;
            line_acc_q <= line_acc_d;
            feat_acc_q <= feat_acc_d;
        end
    end

    // Next-state and loop advance; clear has priority over everything.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        l_d        = l_q;
        f_d        = f_q;
        word_acc_d = word_acc_q;
        line_acc_d = line_acc_q;
        feat_acc_d = feat_acc_q;
        if (clear_i) begin
            state_d    = IDLE;
            w_d        = '0;
            l_d        = '0;
            f_d        = '0;
            word_acc_d = '0;
            line_acc_d = '0;
            feat_acc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        w_d        = '0;
                        l_d        = '0;
                        f_d        = '0;
                        word_acc_d = '0;
                        line_acc_d = '0;
                        feat_acc_d = '0;
                        if (line_length_i == '0 || feat_length_i == '0 || n_feat_i == '0)
                            state_d = DONE;
                        else
                            state_d = RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!word_upd) begin
                            w_d        = w_q + CNT_BITS'(NPX);
                            word_acc_d = word_acc_q + word_step;
                        end else if (!line_upd) begin
                            w_d        = '0;
                            word_acc_d = '0;
                            l_d        = l_q + 1'b1;
                            line_acc_d = line_acc_q + ls_q;
                        end else if (!feat_upd) begin
                            w_d        = '0;
                            word_acc_d = '0;
                            l_d        = '0;
                            line_acc_d = '0;
                            f_d        = f_q + 1'b1;
                            feat_acc_d = feat_acc_q + fs_q;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Lane addresses and masks; everything reads zero outside RUN.
    for (genvar gi = 0; gi < N_STREAMS; gi++) begin : g_stream
        for (genvar gj = 0; gj < NPX; gj++) begin : g_lane
            logic [AW-1:0] lane_off;
            logic [AW-1:0] lane_addr;
            assign lane_off  = AW'(gj) * ws_q;
            assign lane_addr = base_q[gi*AW +: AW] + feat_acc_q + line_acc_q
                             + word_acc_q + lane_off;
            assign gen_addr_o[(gi*NPX+gj)*AW +: AW] = run ? lane_addr : '0;
        end
    end

    for (genvar gi = 0; gi < NPX; gi++) begin : g_mask
        assign lane_mask_o[gi] = run &&
            (({1'b0, w_q} + (CNT_BITS+1)'(gi)) < {1'b0, len_q});
    end

    assign addr_valid_o  = run;
    assign word_update_o = run && word_upd;
    assign line_update_o = run && line_upd;
    assign feat_update_o = run && feat_upd;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_hwpe_axi_addressgen_source_nd.sv
// Bench for the multi-stream source address generator: a loop-walking model
// feeds an expected-beat queue that one monitor checks every output cycle.
module tb_hwpe_axi_addressgen_source_nd;

    localparam int AW  = 32;
    localparam int NS  = 4;
    localparam int NPX = 4;
    localparam int CB  = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start_i = 1'b0;
    logic                    clear_i = 1'b0;
    logic [NS*AW-1:0]        base_addr_i = '0;
    logic [15:0]             word_stride_i = '0;
    logic [CB-1:0]           line_length_i = '0;
    logic [15:0]             line_stride_i = '0;
    logic [CB-1:0]           feat_length_i = '0;
    logic [15:0]             feat_stride_i = '0;
    logic [CB-1:0]           n_feat_i = '0;
    logic                    addr_valid_o;
    logic                    addr_ready_i = 1'b1;
    logic [NS*NPX*AW-1:0]    gen_addr_o;
    logic [NPX-1:0]          lane_mask_o;
    logic                    word_update_o, line_update_o, feat_update_o;
    logic                    busy_o, done_o;

    hwpe_axi_addressgen_source_nd #(
        .ADDR_WIDTH(AW), .N_STREAMS(NS), .NPX(NPX), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i),
        .base_addr_i(base_addr_i), .word_stride_i(word_stride_i),
        .line_length_i(line_length_i), .line_stride_i(line_stride_i),
        .feat_length_i(feat_length_i), .feat_stride_i(feat_stride_i),
        .n_feat_i(n_feat_i), .addr_valid_o(addr_valid_o),
        .addr_ready_i(addr_ready_i), .gen_addr_o(gen_addr_o),
        .lane_mask_o(lane_mask_o), .word_update_o(word_update_o),
        .line_update_o(line_update_o), .feat_update_o(feat_update_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS*NPX*AW-1:0] addr;
        logic [NPX-1:0]       mask;
        logic [2:0]           flg;
    } beat_t;

    beat_t        exp_q[$];
    logic [AW-1:0] lane0_q[$];
    logic [2:0]   flg_q[$];
    logic [NPX-1:0] mask_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_acc_cyc = -10;
    bit rand_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Model: enumerate every beat of the loop nest with plain arithmetic.
    task automatic build_model();
        int nb;
        longint a;
        beat_t bt;
        if (line_length_i == 0 || feat_length_i == 0 || n_feat_i == 0) return;
        nb = (int'(line_length_i) + NPX - 1) / NPX;
        for (int f = 0; f < int'(n_feat_i); f++)
            for (int l = 0; l < int'(feat_length_i); l++)
                for (int b = 0; b < nb; b++) begin
                    for (int i = 0; i < NS; i++)
                        for (int j = 0; j < NPX; j++) begin
                            a = longint'(base_addr_i[i*AW +: AW])
                              + longint'(f) * longint'($signed(feat_stride_i))
                              + longint'(l) * longint'($signed(line_stride_i))
                              + longint'(b*NPX + j) * longint'($signed(word_stride_i));
                            bt.addr[(i*NPX+j)*AW +: AW] = a[AW-1:0];
                        end
                    for (int j = 0; j < NPX; j++)
                        bt.mask[j] = (b*NPX + j) < int'(line_length_i);
                    bt.flg[2] = (b == nb-1);
                    bt.flg[1] = bt.flg[2] && (l == int'(feat_length_i)-1);
                    bt.flg[0] = bt.flg[1] && (f == int'(n_feat_i)-1);
                    exp_q.push_back(bt);
                end
    endtask

    // Ready driver: constant 1 or random.
    initial begin
        forever begin
            @(posedge clk);
            #1 addr_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare outputs to the model head; enforce stall stability.
    logic                 pv = 1'b0, pr = 1'b0;
    logic [NS*NPX*AW-1:0] pa;
    logic [NPX-1:0]       pm;
    logic [2:0]           pf;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst || clear_i) begin
                exp_q.delete();
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("stall_valid", 64'(addr_valid_o), 64'd1);
                    check("stall_stable", 64'({gen_addr_o, lane_mask_o, word_update_o,
                          line_update_o, feat_update_o} == {pa, pm, pf}), 64'd1);
                end
                if (addr_valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        for (int k = 0; k < NS*NPX; k++)
                            check($sformatf("addr[%0d]", k), 64'(gen_addr_o[k*AW +: AW]),
                                  64'(exp_q[0].addr[k*AW +: AW]));
                        check("lane_mask", 64'(lane_mask_o), 64'(exp_q[0].mask));
                        check("flags", 64'({word_update_o, line_update_o, feat_update_o}),
                              64'(exp_q[0].flg));
                        if (addr_ready_i) begin
                            lane0_q.push_back(gen_addr_o[AW-1:0]);
                            flg_q.push_back({word_update_o, line_update_o, feat_update_o});
                            mask_q.push_back(lane_mask_o);
                            void'(exp_q.pop_front());
                            last_acc_cyc = cyc;
                        end
                    end
                end
                if (done_o) begin
                    done_cnt++;
                    check("done_queue_empty", 64'(exp_q.size()), 64'd0);
                    check("done_busy", 64'(busy_o), 64'd1);
                    check("done_novalid", 64'(addr_valid_o), 64'd0);
                end
                pv = addr_valid_o; pr = addr_ready_i;
                pa = gen_addr_o; pm = lane_mask_o;
                pf = {word_update_o, line_update_o, feat_update_o};
            end
        end
    end

    task automatic set_cfg(input logic [AW-1:0] b0, input logic [15:0] ws, input logic [CB-1:0] l,
                           input logic [15:0] ls, input logic [CB-1:0] fl,
                           input logic [15:0] fs, input logic [CB-1:0] nf);
        for (int i = 0; i < NS; i++) base_addr_i[i*AW +: AW] = b0 + AW'(i) * 32'h0001_0000;
        word_stride_i = ws; line_length_i = l; line_stride_i = ls;
        feat_length_i = fl; feat_stride_i = fs; n_feat_i = nf;
    endtask

    task automatic start_xfer();
        lane0_q.delete(); flg_q.delete(); mask_q.delete();
        @(posedge clk);
        #1 start_i = 1'b1;
        build_model();
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_o) begin seen = 1'b1; break; end
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) check({name, "_done_after_last_beat"}, 64'(cyc - last_acc_cyc), 64'd1);
        @(negedge clk);
        check({name, "_idle_after_done"}, 64'({done_o, busy_o}), 64'd0);
    endtask

    logic [AW-1:0] ref_q[$];
    int d0;

    initial begin
        #12;
        check("reset_outputs", 64'({addr_valid_o, lane_mask_o, word_update_o, line_update_o,
              feat_update_o, busy_o, done_o, |gen_addr_o}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Test 1: two lines of 8 words.
        set_cfg(32'h1000, 16'd2, 16'd8, 16'd64, 16'd2, 16'd0, 16'd1);
        start_xfer();
        wait_done("t1");
        check("t1_beats", 64'(lane0_q.size()), 64'd4);
        if (lane0_q.size() == 4) begin
            check("t1_a0", 64'(lane0_q[0]), 64'h1000);
            check("t1_a1", 64'(lane0_q[1]), 64'h1008);
            check("t1_a2", 64'(lane0_q[2]), 64'h1040);
            check("t1_a3", 64'(lane0_q[3]), 64'h1048);
            check("t1_f1", 64'(flg_q[1]), 64'b100);
            check("t1_f3", 64'(flg_q[3]), 64'b111);
        end

        // Test 2: partial last beat.
        set_cfg(32'h1000, 16'd2, 16'd6, 16'd64, 16'd1, 16'd0, 16'd1);
        start_xfer();
        wait_done("t2");
        check("t2_beats", 64'(lane0_q.size()), 64'd2);
        if (lane0_q.size() == 2) begin
            check("t2_m0", 64'(mask_q[0]), 64'b1111);
            check("t2_m1", 64'(mask_q[1]), 64'b0011);
            check("t2_a1", 64'(lane0_q[1]), 64'h1008);
        end

        // Test 3: negative feature stride.
        set_cfg(32'h2000, 16'd1, 16'd4, 16'd0, 16'd1, 16'hFF00, 16'd3);
        start_xfer();
        wait_done("t3");
        check("t3_beats", 64'(lane0_q.size()), 64'd3);
        if (lane0_q.size() == 3) begin
            check("t3_a1", 64'(lane0_q[1]), 64'h1F00);
            check("t3_a2", 64'(lane0_q[2]), 64'h1E00);
            check("t3_f1", 64'(flg_q[1]), 64'b110);
            check("t3_f2", 64'(flg_q[2]), 64'b111);
        end

        // Test 4: random ready versus ready held high.
        set_cfg(32'h3000, 16'hFFFD, 16'd7, 16'd100, 16'd3, 16'h0200, 16'd2);
        start_xfer();
        wait_done("t4a");
        ref_q = lane0_q;
        rand_mode = 1'b1;
        start_xfer();
        wait_done("t4b");
        rand_mode = 1'b0;
        check("t4_beats", 64'(lane0_q.size()), 64'(ref_q.size()));
        check("t4_same_seq", 64'(lane0_q == ref_q), 64'd1);

        // Test 5: clear together with start in the middle of a run.
        set_cfg(32'h4000, 16'd4, 16'd16, 16'd256, 16'd4, 16'd0, 16'd2);
        start_xfer();
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        @(posedge clk); #1 clear_i = 1'b1; start_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        check("t5_idle_after_clear", 64'({busy_o, addr_valid_o}), 64'd0);
        repeat (3) @(negedge clk);
        check("t5_no_done", 64'(done_cnt), 64'(d0));
        set_cfg(32'h5000, 16'd2, 16'd4, 16'd8, 16'd2, 16'd0, 16'd1);
        start_xfer();
        wait_done("t5r");
        if (lane0_q.size() > 0) check("t5_restart_a0", 64'(lane0_q[0]), 64'h5000);

        // Test 6: zero feature length goes straight to DONE.
        set_cfg(32'h6000, 16'd2, 16'd4, 16'd8, 16'd0, 16'd0, 16'd1);
        start_xfer();
        @(negedge clk);
        check("t6_done_pulse", 64'({done_o, addr_valid_o}), 64'b10);
        @(negedge clk);
        check("t6_done_gone", 64'({done_o, addr_valid_o, busy_o}), 64'd0);

        // Test 7: asynchronous reset mid-run.
        set_cfg(32'h7000, 16'd2, 16'd16, 16'd64, 16'd4, 16'd0, 16'd1);
        start_xfer();
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("t7_reset_outputs", 64'({addr_valid_o, lane_mask_o, word_update_o, line_update_o,
              feat_update_o, busy_o, done_o, |gen_addr_o}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t7_idle", 64'({busy_o, addr_valid_o}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
